// File: rtl/pingpong_frame_buffer.sv
// pingpong_frame_buffer
// Two-bank frame store. The writer fills bank r_wb while the reader scans
// bank ~r_wb. A completed frame is held (W_HOLD) until the reader starts a
// new frame with i_rd_sof, at which point the banks swap on that same edge
// and the reader immediately scans the freshly published frame.
//
// Optional feature macro: PINGPONG_DROP_CNT_EN
//   defined   -> o_drop_cnt counts write frames dropped while in W_HOLD
//                (saturating at 16'hFFFF)
//   undefined -> counter not built, o_drop_cnt tied to 16'd0
module pingpong_frame_buffer #(
  parameter int DATA_W = 12,
  parameter int H_RES  = 640,
  parameter int V_RES  = 480
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic              i_wr_sof,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_en,
  input  logic              i_rd_sof,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_valid,
  output logic              o_frame_avail,
  output logic              o_wr_busy,
  output logic [15:0]       o_drop_cnt
);

  localparam int DEPTH  = H_RES * V_RES;
  localparam int ADDR_W = $clog2(DEPTH);
  // The bank bit is the address MSB, so each bank spans a power-of-two
  // range; for power-of-two frame sizes this is exactly 2*DEPTH words.
  localparam int MEM_WORDS = 2 * (2 ** ADDR_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    W_IDLE  = 2'd0,
    W_WRITE = 2'd1,
    W_HOLD  = 2'd2
  } wstate_t;

  // Frame storage: never reset, contents survive rst_n.
  logic [DATA_W-1:0] r_mem [0:MEM_WORDS-1];

  // Writer state
  wstate_t           r_wstate;
  wstate_t           w_wstate_next;
  logic [ADDR_W-1:0] r_waddr;
  logic [ADDR_W-1:0] w_waddr_next;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic              w_complete;

  // Bank / publish state
  logic              r_wb;
  logic              r_pending;
  logic              r_frame_avail;
  logic              w_swap;

  // Reader state
  logic [ADDR_W-1:0] r_raddr;
  logic [ADDR_W-1:0] w_raddr_next;
  logic [ADDR_W-1:0] w_rd_addr;
  logic              w_rd_bank;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;

  // A swap needs a frame that was already pending before this edge, so a
  // completion landing together with rd_sof waits for the next rd_sof.
  assign w_swap = i_rd_sof & r_pending;

  // Writer state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wstate <= W_IDLE;
    end else begin
      r_wstate <= w_wstate_next;
    end
  end

  // Writer next-state, write strobe and write address
  always_comb begin
    w_wstate_next = r_wstate;
    w_waddr_next  = r_waddr;
    w_mem_we      = 1'b0;
    w_mem_waddr   = r_waddr;
    w_complete    = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        // Only a start-of-frame pixel opens a frame; stray pixels are ignored.
        if (i_wr_en && i_wr_sof) begin
          w_mem_we      = 1'b1;
          w_mem_waddr   = '0;
          w_waddr_next  = ADDR_W'(1);
          w_wstate_next = W_WRITE;
        end
      end
      W_WRITE: begin
        if (i_wr_en) begin
          w_mem_we = 1'b1;
          if (i_wr_sof) begin
            // Mid-frame sof abandons the partial frame and restarts at 0.
            w_mem_waddr  = '0;
            w_waddr_next = ADDR_W'(1);
          end else if (r_waddr == LAST_ADDR) begin
            w_mem_waddr   = r_waddr;
            w_waddr_next  = '0;
            w_complete    = 1'b1;
            w_wstate_next = W_HOLD;
          end else begin
            w_mem_waddr  = r_waddr;
            w_waddr_next = r_waddr + 1'b1;
          end
        end
      end
      W_HOLD: begin
        // Writes are suppressed until the reader takes the frame.
        if (w_swap) begin
          w_waddr_next  = '0;
          w_wstate_next = W_IDLE;
        end
      end
      default: begin
        w_wstate_next = W_IDLE;
        w_waddr_next  = '0;
      end
    endcase
  end

  // Writer address, bank select and publish flags
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_waddr       <= '0;
      r_wb          <= 1'b0;
      r_pending     <= 1'b0;
      r_frame_avail <= 1'b0;
    end else begin
      r_waddr <= w_waddr_next;
      if (w_swap) begin
        r_wb          <= ~r_wb;
        r_pending     <= 1'b0;
        r_frame_avail <= 1'b1;
      end else if (w_complete) begin
        r_pending <= 1'b1;
      end
    end
  end

  // On a swap edge the reader already targets the new read bank, which is
  // the current writer bank (the writer is in W_HOLD, so no write collides).
  assign w_rd_bank = w_swap ? r_wb : ~r_wb;
  assign w_rd_addr = i_rd_sof ? '0 : r_raddr;

  // Reader address sequencing with wrap at the end of the frame
  always_comb begin
    w_raddr_next = r_raddr;
    if (i_rd_sof) begin
      w_raddr_next = i_rd_en ? ADDR_W'(1) : '0;
    end else if (i_rd_en) begin
      w_raddr_next = (r_raddr == LAST_ADDR) ? '0 : (r_raddr + 1'b1);
    end
  end

  // Memory write port
  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[{r_wb, w_mem_waddr}] <= i_wr_data;
    end
  end

  // Registered read port: one-cycle latency, data holds when idle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_raddr    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_raddr    <= w_raddr_next;
      r_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        r_rd_data <= r_mem[{w_rd_bank, w_rd_addr}];
      end
    end
  end

`ifdef PINGPONG_DROP_CNT_EN
  logic        w_drop;
  logic [15:0] r_drop_cnt;

  // Every new frame offered while a frame is held is lost.
  assign w_drop = (r_wstate == W_HOLD) & i_wr_en & i_wr_sof;

  // Saturating dropped-frame counter
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_drop_cnt <= 16'd0;
    end else if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
      r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign o_drop_cnt = r_drop_cnt;
`else
  assign o_drop_cnt = 16'd0;
`endif

  assign o_rd_data     = r_rd_data;
  assign o_rd_valid    = r_rd_valid;
  assign o_frame_avail = r_frame_avail;
  assign o_wr_busy     = (r_wstate == W_WRITE);

endmodule
